data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: valid/ready request, fixed wait-state response.
// Optional macro DMEM_RESP_ERR_EN enables out-of-range / misaligned error responses.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                mem_we;
  logic                addr_err;
  logic [29:0]         word;
  logic [IDX_W-1:0]    idx;

  assign word = req_addr_i[31:2];

`ifdef DMEM_RESP_ERR_EN
  assign addr_err = (32'(word) >= DEPTH) || (req_addr_i[1:0] != 2'b00);
  assign idx      = IDX_W'(word);
`else
  // Byte offset is meaningless when every access is a whole word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign addr_err        = 1'b0;
  assign idx             = IDX_W'(32'(word) % DEPTH);
`endif

  assign accept = req_valid_i && (state_q == IDLE);
  assign mem_we = accept && req_we_i && !addr_err;

  // Storage has no reset; writes commit on the accept edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (req_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // State register and response holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: read data and error are captured at accept and held until handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = addr_err;
          rdata_d = (req_we_i || addr_err) ? '0 : mem_q[idx];
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance plus a LATENCY=0 instance
// sharing request/response wiring, steered by 'fast'.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fast;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        rdy2, rv2, err2;
  logic [31:0] rd2;
  logic        rdy0, rv0, err0;
  logic [31:0] rd0;

  logic        ready_s, valid_s, err_s;
  logic [31:0] rdata_s;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid & ~fast), .req_ready_o(rdy2),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(rv2), .resp_ready_i(resp_ready), .resp_rdata_o(rd2), .resp_err_o(err2)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid & fast), .req_ready_o(rdy0),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(rv0), .resp_ready_i(resp_ready), .resp_rdata_o(rd0), .resp_err_o(err0)
  );

  assign ready_s = fast ? rdy0 : rdy2;
  assign valid_s = fast ? rv0  : rv2;
  assign rdata_s = fast ? rd0  : rd2;
  assign err_s   = fast ? err0 : err2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][64];
  int          passed = 0;
  int          total  = 0;
  int unsigned cyc    = 0;
  int unsigned acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
    return (a[31:2] >= 30'd64) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Drive one request until accepted and push its expected response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    exp_t e;
    int   n;
    int   s;
    s = fast ? 1 : 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!ready_s && n < 50) begin @(posedge clk); #1; n++; end
    if (!ready_s) begin
      total++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, ready_s);
    end else begin
      @(posedge clk); #1;
    end
    acc_cyc   = cyc;
    req_valid = 1'b0;
    e.err   = addr_bad(addr);
    e.rdata = '0;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[s][widx(addr)][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = model[s][widx(addr)];
      end
    end
    sb.push_back(e);
  endtask

  // Wait (bounded) for a response; lat counts cycles after the accept edge.
  task automatic collect(output logic [31:0] rd, output logic er, output int lat);
    lat = 1;
    while (!valid_s && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rdata_s;
    er = err_s;
    if (valid_s && resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fast = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rdy2 !== 1'b1) $display("FAIL reset_req_ready got=%b required=1", rdy2); else passed++;
    total++; if (rv2 !== 1'b0) $display("FAIL reset_resp_valid got=%b required=0", rv2); else passed++;
    total++; if (rd2 !== 32'h0) $display("FAIL reset_rdata got=%h required=0", rd2); else passed++;
    total++; if (err2 !== 1'b0) $display("FAIL reset_err got=%b required=0", err2); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    exp_t e; logic [31:0] rd; logic er; int lat;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if (lat !== 3) $display("FAIL wr_latency got=%0d required=3", lat); else passed++;
    total++; if ({er, rd} !== {e.err, e.rdata})
      $display("FAIL wr_resp got=%b/%h required=%b/%h", er, rd, e.err, e.rdata); else passed++;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if (lat !== 3) $display("FAIL rd_latency got=%0d required=3", lat); else passed++;
    total++; if ({er, rd} !== {e.err, e.rdata})
      $display("FAIL rd_resp got=%b/%h required=%b/%h", er, rd, e.err, e.rdata); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_deadbeef got=%h required=deadbeef", rd); else passed++;
  endtask

  task automatic test_byte_enable();
    exp_t e; logic [31:0] rd; logic er; int lat;
    logic [31:0] wd [4];
    logic [3:0]  be [4];
    wd[0] = 32'h11223344; be[0] = 4'hF;
    wd[1] = 32'hAABBCCDD; be[1] = 4'h5;
    wd[2] = 32'hFFFFFFFF; be[2] = 4'h0;
    wd[3] = 32'h0;        be[3] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      issue(i != 3, 32'h20, wd[i], be[i]);
      collect(rd, er, lat); e = sb.pop_front();
      total++; if ({er, rd} !== {e.err, e.rdata} || lat !== 3)
        $display("FAIL be_step%0d got=%b/%h lat=%0d required=%b/%h lat=3", i, er, rd, lat, e.err, e.rdata);
      else passed++;
    end
    total++; if (rd !== 32'h11BB33DD) $display("FAIL be_merge got=%h required=11bb33dd", rd); else passed++;
  endtask

  task automatic test_backpressure();
    exp_t e; logic [31:0] rd; logic er; int lat;
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if ({er, rd} !== {e.err, e.rdata} || lat !== 3)
      $display("FAIL bp_resp got=%b/%h lat=%0d required=%b/%h lat=3", er, rd, lat, e.err, e.rdata);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (valid_s !== 1'b1 || rdata_s !== e.rdata || ready_s !== 1'b0)
        $display("FAIL bp_hold%0d valid=%b rdata=%h ready=%b required 1/%h/0", i, valid_s, rdata_s, ready_s, e.rdata);
      else passed++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_s !== 1'b1 || valid_s !== 1'b0)
      $display("FAIL bp_release ready=%b valid=%b required 1/0", ready_s, valid_s); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] rd; logic er; int lat; int unsigned a1;
    fast = 1'b1;
    issue(1'b1, 32'h08, 32'hCAFEF00D, 4'hF); collect(rd, er, lat); e = sb.pop_front();
    issue(1'b1, 32'h0C, 32'h12345678, 4'hF); collect(rd, er, lat); e = sb.pop_front();
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    a1 = acc_cyc;
    collect(rd, er, lat); e = sb.pop_front();
    total++; if (lat !== 1) $display("FAIL b2b_lat0 got=%0d required=1", lat); else passed++;
    total++; if ({er, rd} !== {e.err, e.rdata})
      $display("FAIL b2b_rd0 got=%b/%h required=%b/%h", er, rd, e.err, e.rdata); else passed++;
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    total++; if (acc_cyc - a1 !== 2) $display("FAIL b2b_period got=%0d required=2", acc_cyc - a1); else passed++;
    collect(rd, er, lat); e = sb.pop_front();
    total++; if (lat !== 1) $display("FAIL b2b_lat1 got=%0d required=1", lat); else passed++;
    total++; if ({er, rd} !== {e.err, e.rdata} || rd !== 32'h12345678)
      $display("FAIL b2b_rd1 got=%b/%h required=%b/%h", er, rd, e.err, e.rdata); else passed++;
    fast = 1'b0;
  endtask

  task automatic test_addr_wrap();
    exp_t e; logic [31:0] rd; logic er; int lat;
    logic exp_err; logic [31:0] exp_w0;
`ifdef DMEM_RESP_ERR_EN
    exp_err = 1'b1; exp_w0 = 32'h0BADF00D;
`else
    exp_err = 1'b0; exp_w0 = 32'h5A5A5A5A;
`endif
    issue(1'b1, 32'h0, 32'h0BADF00D, 4'hF); collect(rd, er, lat); e = sb.pop_front();
    issue(1'b1, 32'h100, 32'h5A5A5A5A, 4'hF);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if ({er, rd} !== {e.err, e.rdata} || er !== exp_err || lat !== 3)
      $display("FAIL wrap_wr got=%b/%h lat=%0d required=%b/%h lat=3", er, rd, lat, exp_err, e.rdata);
    else passed++;
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if ({er, rd} !== {e.err, e.rdata} || rd !== exp_w0)
      $display("FAIL wrap_word0 got=%b/%h required=%b/%h", er, rd, e.err, exp_w0); else passed++;
    issue(1'b0, 32'h2, 32'h0, 4'h0);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if ({er, rd} !== {e.err, e.rdata} || lat !== 3)
      $display("FAIL misalign_rd got=%b/%h lat=%0d required=%b/%h lat=3", er, rd, lat, e.err, e.rdata);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] rd; logic er; int lat; int seen;
    issue(1'b1, 32'h04, 32'h13579BDF, 4'hF);
    e = sb.pop_front();
    rst_n = 1'b0;
    seen  = 0;
    for (int i = 0; i < 3; i++) begin
      if (valid_s) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0 || ready_s !== 1'b1)
      $display("FAIL rst_mid_hold valid_cycles=%0d ready=%b required 0/1", seen, ready_s); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_s !== 1'b1 || valid_s !== 1'b0)
      $display("FAIL rst_mid_release ready=%b valid=%b required 1/0", ready_s, valid_s); else passed++;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    collect(rd, er, lat); e = sb.pop_front();
    total++; if ({er, rd} !== {e.err, e.rdata} || rd !== 32'h13579BDF)
      $display("FAIL rst_mid_persist got=%b/%h required=0/13579bdf", er, rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
